// File: rtl/reg_pkg.sv
// Shared register-select definitions: sizes, FSM states
// and the code-to-one-hot decode used by the enable decoder.
package reg_pkg;

  localparam int REG_COUNT  = 8;
  localparam int REG_CODE_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [REG_COUNT-1:0] code_to_onehot(
    input logic [REG_CODE_W-1:0] code
  );
    logic [REG_COUNT-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/reg_select_encoder_rr_pick.sv
// Rotated first-set search: lowest set bit of req at or
// above ptr, wrapping through 0..ptr-1.
module rr_pick
  import reg_pkg::*;
(
  input  logic [REG_COUNT-1:0]  req,
  input  logic [REG_CODE_W-1:0] ptr,
  output logic                  found,
  output logic [REG_CODE_W-1:0] idx
);

  logic [2*REG_COUNT-1:0] dbl;
  logic [REG_COUNT-1:0]   rot;

  assign dbl = {req, req} >> ptr;
  assign rot = dbl[REG_COUNT-1:0];

  // Scan downward so the lowest rotated position wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        idx   = ptr + REG_CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/reg_select_encoder.sv
// Round-robin requester arbiter producing a register code,
// strobe and one-hot grant, with an ack/withdraw/watchdog exit.
module reg_select_encoder
  import reg_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_COUNT-1:0]  req,
  input  logic                  ack,
  output logic                  signal,
  output logic [REG_CODE_W-1:0] reg_code,
  output logic [REG_COUNT-1:0]  grant,
  output logic                  timeout
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit TO_EN = (TIMEOUT > 0);

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [REG_CODE_W-1:0]   ptr, ptr_d;
  logic [REG_CODE_W-1:0]   code_d;
  logic                    signal_d, timeout_d;
  logic [REG_COUNT-1:0]    grant_d;
  logic                    found;
  logic [REG_CODE_W-1:0]   pick_idx;
  logic                    held, to_hit;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign held   = req[reg_code];
  assign to_hit = TO_EN && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      signal   <= 1'b0;
      reg_code <= '0;
      grant    <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ptr      <= ptr_d;
      signal   <= signal_d;
      reg_code <= code_d;
      grant    <= grant_d;
      timeout  <= timeout_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (found) state_d = GRANT;
      GRANT: if (ack || !held || to_hit)
               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt;
    ptr_d     = ptr;
    signal_d  = signal;
    code_d    = reg_code;
    grant_d   = grant;
    timeout_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          signal_d = 1'b1;
          code_d   = pick_idx;
          grant_d  = code_to_onehot(pick_idx);
          cnt_d    = '0;
        end
      end
      GRANT: begin
        if (state_d == IDLE) begin
          signal_d = 1'b0;
          code_d   = '0;
          grant_d  = '0;
          ptr_d    = reg_code + REG_CODE_W'(1);
          // Only the watchdog exits with both ack low and req held.
          timeout_d = !ack && held;
        end else if (cnt != '1) begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_select_encoder.sv
// Directed bench for reg_select_encoder with a cycle model
// and literal checks on hand-derived grant sequences.
module tb_reg_select_encoder;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic       signal;
  logic [2:0] reg_code;
  logic [7:0] grant;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  reg_select_encoder #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .signal   (signal),
    .reg_code (reg_code),
    .grant    (grant),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: busy flag, owner, rotating start, age.
  logic       m_busy;
  logic [2:0] m_code;
  logic [2:0] m_ptr;
  int         m_age;
  logic       m_to;

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_code <= 3'd0;
      m_ptr  <= 3'd0;
      m_age  <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_busy) begin
        w = -1;
        for (int k = 0; k < 8; k++)
          if (w < 0 && req[(int'(m_ptr) + k) % 8])
            w = (int'(m_ptr) + k) % 8;
        if (w >= 0) begin
          m_busy <= 1'b1;
          m_code <= 3'(w);
          m_age  <= 1;
        end
      end else if (ack || !req[m_code] ||
                   (TO > 0 && m_age == TO)) begin
        m_busy <= 1'b0;
        m_ptr  <= m_code + 3'd1;
        m_to   <= !ack && req[m_code];
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] eg;
    eg = m_busy ? (8'd1 << m_code) : 8'd0;
    chk("m_signal", 32'(signal), 32'(m_busy));
    chk("m_code", 32'(reg_code),
        m_busy ? 32'(m_code) : 32'd0);
    chk("m_grant", 32'(grant), 32'(eg));
    chk("m_timeout", 32'(timeout), 32'(m_to));
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    ack   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    ack   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests.
    repeat (10) begin
      @(negedge clk);
      chk("idle_sig", 32'(signal), 32'd0);
      chk("idle_grant", 32'(grant), 32'd0);
    end

    // Single request, acked after one cycle.
    req = 8'h20;
    @(negedge clk);
    chk("single_code", 32'(reg_code), 32'd5);
    chk("single_grant", 32'(grant), 32'h20);
    ack = 1'b1;
    @(negedge clk);
    chk("single_rel", 32'(signal), 32'd0);
    req = 8'h41;
    ack = 1'b0;
    @(negedge clk);
    chk("ptr6_code", 32'(reg_code), 32'd6);
    ack = 1'b1;
    @(negedge clk);
    req = 8'h00;
    ack = 1'b0;
    @(negedge clk);

    // Contention between bits 0 and 7.
    do_reset();
    req = 8'h81;
    ack = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rr_code", 32'(reg_code),
          (n % 2 == 0) ? 32'd0 : 32'd7);
      @(negedge clk);
      chk("rr_bubble", 32'(signal), 32'd0);
    end
    req = 8'h00;
    ack = 1'b0;
    @(negedge clk);

    // Watchdog release after TO cycles.
    do_reset();
    req = 8'h04;
    for (int n = 0; n < TO; n++) begin
      @(negedge clk);
      chk("to_hold", 32'(signal), 32'd1);
      chk("to_nopulse", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    chk("to_rel", 32'(signal), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    req = 8'h0C;
    @(negedge clk);
    chk("to_regrant", 32'(reg_code), 32'd3);
    chk("to_clear", 32'(timeout), 32'd0);
    ack = 1'b1;
    @(negedge clk);
    req = 8'h00;
    ack = 1'b0;
    @(negedge clk);

    // Withdraw mid-grant.
    do_reset();
    req = 8'h08;
    @(negedge clk);
    chk("wd_code", 32'(reg_code), 32'd3);
    req = 8'h00;
    @(negedge clk);
    chk("wd_rel", 32'(signal), 32'd0);
    chk("wd_noto", 32'(timeout), 32'd0);

    // Ack and withdraw together.
    req = 8'h08;
    @(negedge clk);
    chk("tie_code", 32'(reg_code), 32'd3);
    req = 8'h00;
    ack = 1'b1;
    @(negedge clk);
    chk("tie_rel", 32'(signal), 32'd0);
    chk("tie_noto", 32'(timeout), 32'd0);
    ack = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-grant.
    do_reset();
    req = 8'h40;
    @(negedge clk);
    chk("ar_code", 32'(reg_code), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_sig", 32'(signal), 32'd0);
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_code0", 32'(reg_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'hFF;
    @(negedge clk);
    chk("ar_first", 32'(reg_code), 32'd0);
    chk("ar_fgrant", 32'(grant), 32'h01);
    ack = 1'b1;
    @(negedge clk);
    req = 8'h00;
    ack = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_select_encoder.md
# reg_select_encoder

Round-robin request encoder for the register file: eight requesters each raise a line to claim the register-write path, and this block arbitrates among them. It produces the 3-bit register code plus a strobe that feed the existing one-hot register-enable decoder, closing the loop from code to enable and back. The winner holds the grant until the consumer acknowledges, the requester withdraws, or a watchdog times out.

## Interface
- `TIMEOUT`, default 16: cycles a grant may stay unacknowledged before forced release; 0 disables the watchdog.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request lines; bit i claims register i.
- `ack`  in  1  consumer accepted the current code; sampled only in GRANT.
- `signal`  out  1  code valid strobe, high for the whole grant.
- `reg_code`  out  3  encoded index of the granted requester; 3'b000 when `signal`=0.
- `grant`  out  8  one-hot grant to requesters, equal to decode of `reg_code` when `signal`=1, else 8'h00.
- `timeout`  out  1  one-cycle pulse when the watchdog forces release.

## Operation
- States: IDLE, GRANT. All outputs are registered.
- Reset (async assert, sync deassert to `clk`): state IDLE, `signal`=0, `reg_code`=0, `grant`=0, `timeout`=0, priority pointer `ptr`=0, watchdog counter=0.
- IDLE, `req`=0: remain in IDLE.
- IDLE, `req`!=0: pick the first set bit searching from `ptr` upward with wrap (ptr..7, then 0..ptr-1). Register its index into `reg_code`, set `signal`, set the matching `grant` bit, clear the counter, and go to GRANT.
- GRANT exits. Priority is `ack` > withdraw > timeout:
  - `ack`=1: go to IDLE.
  - `req[reg_code]`=0 (requester withdrew): go to IDLE.
  - counter reaches `TIMEOUT`-1 with `TIMEOUT`>0: go to IDLE and pulse `timeout` for 1 cycle.
- Every GRANT exit sets `ptr` = `reg_code`+1, modulo 8. `ptr` wrapping from 7 to 0 is natural 3-bit overflow.
- Otherwise the block stays in GRANT, increments the counter, and holds `reg_code` stable. Changes on other `req` bits are ignored while in GRANT.
- Counter width is $clog2(TIMEOUT+1), minimum 1. It saturates and never wraps.
- `ack` in IDLE is ignored.

## Timing
- Request to grant latency: `req` bit set at edge N is seen at edge N+1 with `signal`=1.
- `ack` high at edge M: `signal`=0 after edge M+1.
- A new grant is issued no earlier than edge M+2, so there is at least one IDLE bubble cycle between grants.
- Minimum grant length is 1 cycle, when `ack` is already high on the first GRANT cycle.
- Forced release: the timeout fires after exactly `TIMEOUT` cycles in GRANT, with `timeout` high during the first IDLE cycle.
- Reset mid-grant: all outputs drop asynchronously on `rst_n` low, and the grant resumes from `ptr`=0 after release.

## Structure
- Shared package `reg_pkg`:
  - `REG_COUNT`=8 and `REG_CODE_W`=3.
  - State enum {IDLE, GRANT}.
  - A function that decodes a code to one-hot, shared with the decoder side.
- One sub-module, `rr_pick`: combinational. Takes `req[7:0]` and `ptr[2:0]`; returns `found` and `idx[2:0]` for the rotated first-set search. The FSM, counter and output registers stay in the top.

## Test plan
- Reset then `req`=8'h00 for 10 cycles: `signal`=0, `grant`=0 throughout.
- Single request `req`=8'h20, `ack` one cycle later: `reg_code`=5, `grant`=8'h20 for 1 cycle. `ptr` becomes 6.
- Contention `req`=8'h81 held, acknowledging each grant: grants alternate 0, 7, 0, 7, and `ptr` wraps 7 to 0 correctly.
- Timeout with `TIMEOUT`=4, `req`=8'h04, `ack`=0: `signal` high for exactly 4 cycles, then a `timeout` pulse, `ptr`=3. Regrant after the bubble.
- Withdraw and tie-break:
  - `req[3]` dropped mid-grant: IDLE next cycle, no `timeout`.
  - `ack` and withdraw in the same cycle: same exit, no `timeout`.
- Async reset: `rst_n` low mid-grant with `reg_code`=6: `signal`, `grant`, `reg_code` go to 0 without a clock edge. The first grant after reset with `req`=8'hFF is `reg_code`=0.
